// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-side signals of fifo_wr_arbiter.
// The master modport is the arbiter; the slave modport is the producers plus FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_overflow;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic [ID_W-1:0]               grant_id;

  modport master (
    input  req_valid, req_lock, req_data, fifo_full, fifo_almostfull, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id
  );

  modport slave (
    output req_valid, req_lock, req_data, fifo_full, fifo_almostfull, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with locked bursts capped at MAX_BURST beats and full/almostfull throttling.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.master    bus,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 err_overflow
);
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       owner;
  logic [ID_W-1:0]       sel;
  logic [BURST_W-1:0]    burst_cnt;
  logic                  issue_ok;
  logic                  xfer;
  logic [FIFO_WIDTH-1:0] sel_data;

  // The registered write already in flight may take the last free slot.
  assign issue_ok = !bus.fifo_full && !(bus.fifo_wr_en && bus.fifo_almostfull);
  assign locked   = (state == ST_LOCKED);

  always_comb begin
    int idx;
    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    idx           = 0;
    sel           = owner;
    bus.req_ready = '0;
    if (state == ST_IDLE) begin
      sel = last_grant;
      // Scan downwards so the nearest requester after last_grant is the one kept.
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = int'(last_grant) + k;
        if (idx >= NUM_REQ) idx -= NUM_REQ;
        if (bus.req_valid[idx]) sel = ID_W'(idx);
      end
    end
    xfer     = bus.req_valid[sel] && issue_ok;
    sel_data = bus.req_data[int'(sel)*FIFO_WIDTH +: FIFO_WIDTH];
    if (xfer) bus.req_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      last_grant       <= ID_W'(NUM_REQ - 1);
      owner            <= '0;
      burst_cnt        <= '0;
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_data_in <= '0;
      bus.grant_id     <= '0;
      beat_cnt         <= '0;
      err_overflow     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus.fifo_wr_en <= xfer;
      if (bus.fifo_overflow && bus.fifo_wr_en) err_overflow <= 1'b1;
      if (xfer) begin
        bus.fifo_data_in <= sel_data;
        bus.grant_id     <= sel;
        last_grant       <= sel;
        if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        if (state == ST_IDLE) begin
          if (bus.req_lock[sel]) begin
            state     <= ST_LOCKED;
            owner     <= sel;
            burst_cnt <= BURST_W'(1);
          end
        end else begin
          burst_cnt <= burst_cnt + BURST_W'(1);
          // Forced release after MAX_BURST beats; last_grant=owner moves the search on.
          if (!bus.req_lock[sel] || burst_cnt == BURST_LAST) state <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a cycle-level reference model checked every
// cycle, plus literal grant-order and flag expectations for each scenario.
module tb_fifo_wr_arbiter;
  localparam int NR   = 4;
  localparam int FW   = 16;
  localparam int MB   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          locked;
  logic [CW-1:0] beat_cnt;
  logic          err_overflow;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(FW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(FW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .locked       (locked),
    .beat_cnt     (beat_cnt),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int total [NR];
  int lockn [NR];
  int sent  [NR];
  logic [NR-1:0] fired_q = '0;
  int log_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer i presents beat sent[i]; its first lockn[i] beats carry lock=1.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = sent[i] < total[i];
      bus.req_lock[i]  = sent[i] < lockn[i];
      bus.req_data[i*FW +: FW] = {4'(i), 12'(sent[i])};
    end
  endtask

  task automatic start(input int t0, t1, t2, t3, input int l0, l1, l2, l3);
    total = '{t0, t1, t2, t3};
    lockn = '{l0, l1, l2, l3};
    sent  = '{0, 0, 0, 0};
    log_q.delete();
    drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (fired_q[i]) sent[i]++;
    drive();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NR; i++) if (sent[i] < total[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      done = all_done() && !bus.fifo_wr_en;
    end
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: timeout, producers still pending", name);
    end
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    check({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check(name, log_q[i], exp_q[i]);
  endtask

  // Reference model: predicts ready from the arbitration rules and the registered
  // outputs one cycle later; compared against the DUT on every falling edge.
  initial begin
    bit            m_wr_en, m_err, m_locked;
    int            m_data, m_grant, m_cnt, m_last, m_owner, m_burst, cand;
    logic [NR-1:0] exp_ready;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_wr_en = 0; m_err = 0; m_locked = 0; m_data = 0; m_grant = 0;
        m_cnt = 0; m_last = NR - 1; m_owner = 0; m_burst = 0;
        fired_q = '0;
        check("rst_wr_en", bus.fifo_wr_en, 0);
        check("rst_data", bus.fifo_data_in, 0);
        check("rst_grant", bus.grant_id, 0);
        check("rst_locked", locked, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_err", err_overflow, 0);
      end else begin
        cand = -1;
        if (m_locked) begin
          if (bus.req_valid[m_owner]) cand = m_owner;
        end else begin
          for (int k = 1; k <= NR; k++)
            if (cand < 0 && bus.req_valid[(m_last + k) % NR]) cand = (m_last + k) % NR;
        end
        exp_ready = '0;
        if (cand >= 0 && !bus.fifo_full && !(m_wr_en && bus.fifo_almostfull))
          exp_ready[cand] = 1'b1;

        check("req_ready", bus.req_ready, exp_ready);
        check("fifo_wr_en", bus.fifo_wr_en, m_wr_en);
        check("fifo_data_in", bus.fifo_data_in, m_data);
        check("grant_id", bus.grant_id, m_grant);
        check("locked", locked, m_locked);
        check("beat_cnt", beat_cnt, m_cnt);
        check("err_overflow", err_overflow, m_err);
        if (bus.fifo_wr_en) log_q.push_back(int'(bus.grant_id));
        fired_q = bus.req_valid & bus.req_ready;

        if (bus.fifo_overflow && m_wr_en) m_err = 1;
        m_wr_en = (exp_ready != '0);
        if (m_wr_en) begin
          m_data  = int'(bus.req_data[cand*FW +: FW]);
          m_grant = cand;
          m_last  = cand;
          if (m_cnt < CMAX) m_cnt++;
          if (m_locked) begin
            m_burst++;
            if (!bus.req_lock[cand] || m_burst == MB) m_locked = 0;
          end else if (bus.req_lock[cand]) begin
            m_locked = 1;
            m_owner  = cand;
            m_burst  = 1;
          end
        end
      end
    end
  end

  initial begin
    int e[$];
    bus.req_valid = '0; bus.req_lock = '0; bus.req_data = '0;
    bus.fifo_full = 1'b0; bus.fifo_almostfull = 1'b0; bus.fifo_overflow = 1'b0;
    start(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // 1: all four request, no locks -> plain rotation from producer 0
    rst = 1'b0;
    start(2, 1, 1, 1, 0, 0, 0, 0);
    wait_idle("t1");
    e = '{0, 1, 2, 3, 0};
    check_log("t1_order", e);
    check("t1_beat_cnt", beat_cnt, 5);

    // 2: producer 2 locks three beats then releases; producer 0 waits
    start(1, 0, 4, 0, 0, 0, 3, 0);
    wait_idle("t2");
    e = '{2, 2, 2, 2, 0};
    check_log("t2_order", e);

    // 3: producer 1 locked for 12 beats -> forced rotation after MAX_BURST
    start(1, 12, 0, 0, 0, 11, 0, 0);
    wait_idle("t3");
    e = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    check_log("t3_order", e);
    check("t3_beat_cnt_sat", beat_cnt, CMAX);

    // 4a: almostfull with a write in flight blocks the next beat
    bus.fifo_almostfull = 1'b1;
    start(3, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("t4_af_first_ready", bus.req_ready, 4'b0001);
    tick();
    @(negedge clk); #1;
    check("t4_af_wr_en", bus.fifo_wr_en, 1);
    check("t4_af_blocked", bus.req_ready, 4'b0000);
    wait_idle("t4a");
    bus.fifo_almostfull = 1'b0;

    // 4b: full rising together with the request blocks it until full drops
    bus.fifo_full = 1'b1;
    start(2, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("t4_full_ready", bus.req_ready, 4'b0000);
    repeat (3) begin
      tick();
      @(negedge clk); #1;
      check("t4_full_no_wr", bus.fifo_wr_en, 0);
    end
    tick();
    bus.fifo_full = 1'b0;
    wait_idle("t4b");
    e = '{0, 0};
    check_log("t4_order", e);

    // 5: overflow seen during a write sets the sticky error
    bus.fifo_overflow = 1'b1;
    start(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    bus.fifo_overflow = 1'b0;
    wait_idle("t5");
    repeat (3) tick();
    check("t5_err_sticky", err_overflow, 1);

    // 6: reset in the middle of a locked burst
    start(0, 0, 10, 0, 0, 0, 10, 0);
    for (int c = 0; c < 50 && sent[2] < 3; c++) tick();
    n_checks++;
    if (sent[2] != 3) begin
      n_err++;
      $display("FAIL t6_reach_burst3: sent %0d expected 3", sent[2]);
    end
    check("t6_locked_before", locked, 1);
    check("t6_wr_en_before", bus.fifo_wr_en, 1);
    rst = 1'b1;
    start(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t6_async_wr_en", bus.fifo_wr_en, 0);
    check("t6_async_locked", locked, 0);
    check("t6_async_err", err_overflow, 0);
    check("t6_async_cnt", beat_cnt, 0);
    check("t6_async_grant", bus.grant_id, 0);
    check("t6_async_data", bus.fifo_data_in, 0);
    repeat (2) tick();
    rst = 1'b0;
    start(1, 1, 1, 1, 0, 0, 0, 0);
    wait_idle("t6");
    e = '{0, 1, 2, 3};
    check_log("t6_order", e);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
